huffman_bit_packer: RTL and testbench

//   Downstream stage of the Huffman encoder top. Takes its serial code stream
//   (Out = code bit, Outt = bit strobe), packs bits MSB-first into WORD_W-bit

---
 rtl/huffman_pkg.sv | 27 ++
 rtl/huffman_sync_fifo.sv | 80 ++++++++
 rtl/huffman_bit_packer.sv | 166 ++++++++++++++++
 tb/tb_huffman_bit_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman bit packer.
//   WORD_W        packed word width (fixed at 8)
//   IDX_W/PAD_W   widths of the bit index and zero-pad count
//   CNT_W         width of the saturating bit counter
//   state_e       packer FSM states
//   fifo_entry_t  one buffered output word with its stream-end tag
package huffman_pkg;

    localparam int WORD_W = 8;
    localparam int IDX_W  = $clog2(WORD_W);
    localparam int PAD_W  = 3;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic              last;
        logic [PAD_W-1:0]  pad;
        logic [WORD_W-1:0] word;
    } fifo_entry_t;

endpackage

// File: rtl/huffman_sync_fifo.sv
// Synchronous FIFO with registered read/write pointers (one extra wrap bit
// distinguishes full from empty).
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clr_i               synchronous clear of both pointers
//   push_i/push_data_i  write request; honoured when not full or when a pop
//                       happens in the same cycle
//   pop_i               read request; ignored when empty
//   tail_upd_i/_data_i  overwrite the most recently written entry
//   head_o, tail_o      oldest and newest stored entries
//   full_o, empty_o     occupancy flags
module huffman_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             tail_upd_i,
    input  logic [WIDTH-1:0] tail_data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [WIDTH-1:0] tail_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    tail_idx;
    logic             do_push, do_pop;

    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop_i && !empty_o;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign do_push  = push_i && (!full_o || do_pop);
    assign tail_idx = wr_ptr_q[AW-1:0] - AW'(1);

    assign head_o = mem_q[rd_ptr_q[AW-1:0]];
    assign tail_o = mem_q[tail_idx];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is visible until a pointer moves.
    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            if (do_push)
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
            else if (tail_upd_i && !empty_o)
                mem_q[tail_idx] <= tail_data_i;
        end
    end

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs the Huffman encoder's serial code stream MSB-first into bytes,
// buffers them and hands them off over a valid/ready port.
//   Clk_in, n_Rst           clock, asynchronous active-low reset
//   Start                   restart: clears counters, FIFO, Done; enters COLLECT
//   Bit_in, Bit_valid       serial code bit and its strobe
//   Flush                   end of stream; pads and tags the final word
//   Word_out/_valid/_ready  FIFO head handshake
//   Word_last, Pad_bits     stream-end tag and zero-pad count of the head word
//   Bit_count               bits accepted since Start, saturating
//   Overflow                sticky; a completed word was dropped on a full FIFO
//   Done                    one-cycle pulse once the flushed stream has drained
module huffman_bit_packer
    import huffman_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk_in,
    input  logic              n_Rst,
    input  logic              Start,
    input  logic              Bit_in,
    input  logic              Bit_valid,
    input  logic              Flush,
    output logic [WORD_W-1:0] Word_out,
    output logic              Word_valid,
    input  logic              Word_ready,
    output logic              Word_last,
    output logic [PAD_W-1:0]  Pad_bits,
    output logic [CNT_W-1:0]  Bit_count,
    output logic              Overflow,
    output logic              Done
);

    state_e             state_q;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               ovf_q;
    logic               done_q;

    fifo_entry_t        push_entry, head_entry, tail_entry, tail_new;
    logic               fifo_full, fifo_empty;
    logic               push, pop, tail_upd;
    logic               bit_acc, flush_acc, word_done;

    function automatic logic [PAD_W-1:0] pad_for(input logic [IDX_W-1:0] fill);
        int p;
        p = WORD_W - int'(fill);
        return p[PAD_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Start takes priority over any bit or flush presented in the same cycle.
    assign bit_acc   = (state_q == ST_COLLECT) && Bit_valid && !Start;
    assign flush_acc = (state_q == ST_COLLECT) && Flush && !Start;
    assign word_done = bit_acc && (idx_q == IDX_W'(WORD_W - 1));
    assign pop       = Word_valid && Word_ready;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (bit_acc) begin
            shift_d[IDX_W'(WORD_W - 1) - idx_q] = Bit_in;
            idx_d = word_done ? '0 : idx_q + IDX_W'(1);
        end
    end

    // A word completed by the flush cycle's own bit is the last word and
    // carries no padding; otherwise a flush with pending bits pushes the
    // zero-filled remainder, and a flush on a word boundary re-tags the
    // newest buffered word.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        tail_upd   = 1'b0;
        tail_new   = tail_entry;
        tail_new.last = 1'b1;
        tail_new.pad  = '0;
        if (word_done) begin
            push            = 1'b1;
            push_entry.last = flush_acc;
            push_entry.word = shift_d;
        end else if (flush_acc && idx_d != '0) begin
            push            = 1'b1;
            push_entry.last = 1'b1;
            push_entry.pad  = pad_for(idx_d);
            push_entry.word = shift_d;
        end else if (flush_acc) begin
            tail_upd = !fifo_empty;
        end
    end

    huffman_sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (Clk_in),
        .rst_ni      (n_Rst),
        .clr_i       (Start),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .tail_upd_i  (tail_upd),
        .tail_data_i (tail_new),
        .head_o      (head_entry),
        .tail_o      (tail_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge Clk_in or negedge n_Rst) begin
        if (!n_Rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            bit_cnt_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Overflow survives Start; only n_Rst clears it.
            if (push && fifo_full && !pop)
                ovf_q <= 1'b1;
            if (Start) begin
                state_q   <= ST_COLLECT;
                shift_q   <= '0;
                idx_q     <= '0;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_COLLECT: begin
                        if (bit_acc)
                            bit_cnt_q <= sat_inc(bit_cnt_q);
                        if (word_done || flush_acc) begin
                            shift_q <= '0;
                            idx_q   <= '0;
                        end else begin
                            shift_q <= shift_d;
                            idx_q   <= idx_d;
                        end
                        if (flush_acc)
                            state_q <= ST_FLUSH;
                    end
                    ST_FLUSH: begin
                        if (fifo_empty) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Word_valid = !fifo_empty;
    assign Word_out   = Word_valid ? head_entry.word : '0;
    assign Word_last  = Word_valid ? head_entry.last : 1'b0;
    assign Pad_bits   = Word_valid ? head_entry.pad  : '0;
    assign Bit_count  = bit_cnt_q;
    assign Overflow   = ovf_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_huffman_bit_packer.sv
module tb_huffman_bit_packer;
    import huffman_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_vld = 1'b0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  word_out;
    logic        word_valid;
    logic        word_last;
    logic [2:0]  pad_bits;
    logic [15:0] bit_count;
    logic        overflow;
    logic        done;

    huffman_bit_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .Clk_in     (clk),
        .n_Rst      (rst_n),
        .Start      (start),
        .Bit_in     (bit_in),
        .Bit_valid  (bit_vld),
        .Flush      (flush),
        .Word_out   (word_out),
        .Word_valid (word_valid),
        .Word_ready (ready),
        .Word_last  (word_last),
        .Pad_bits   (pad_bits),
        .Bit_count  (bit_count),
        .Overflow   (overflow),
        .Done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] word;
        logic       last;
        logic [2:0] pad;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_shift = '0;
    int         m_idx = 0;
    int         m_cnt = 0;
    int         m_occ = 0;
    bit         lat_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---- reference model ----
    task automatic m_push(input logic [7:0] w, input logic last, input logic [2:0] pad);
        exp_t e;
        if (m_occ >= DEPTH) return;   // dropped; overflow expected
        e.word = w; e.last = last; e.pad = pad;
        e.cyc  = cyc + 1;
        e.lat  = lat_chk;
        sb.push_back(e);
        m_occ++;
    endtask

    task automatic m_bit(input logic b);
        m_shift[7 - m_idx] = b;
        m_idx++;
        if (m_cnt < 16'hFFFF) m_cnt++;
        if (m_idx == 8) begin
            m_push(m_shift, 1'b0, 3'd0);
            m_shift = '0;
            m_idx   = 0;
        end
    endtask

    // ---- drivers ----
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bit_vld = 1'b0; flush = 1'b0; start = 1'b0;
        end
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        bit_in = b; bit_vld = 1'b1;
        m_bit(b);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i >= 8 - n; i--) drive_bit(v[i]);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1; bit_vld = 1'b0; flush = 1'b0;
        sb.delete();
        m_occ = 0; m_shift = '0; m_idx = 0; m_cnt = 0;
        idle(1);
    endtask

    task automatic do_flush(input bit with_bit, input logic b);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b1; bit_vld = with_bit; bit_in = b;
        if (with_bit) begin
            m_shift[7 - m_idx] = b;
            m_idx++;
            m_cnt++;
        end
        if (m_idx == 8)
            m_push(m_shift, 1'b1, 3'd0);
        else if (m_idx > 0)
            m_push(m_shift, 1'b1, 3'(8 - m_idx));
        else if (sb.size() > 0) begin
            e = sb.pop_back();
            e.last = 1'b1;
            e.pad  = 3'd0;
            sb.push_back(e);
        end
        m_shift = '0;
        m_idx   = 0;
        idle(1);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
        if (seen) begin
            @(negedge clk);
            check({tag, "_pulse_width"}, 32'(done), 32'd0);
        end
    endtask

    // ---- scoreboard monitor ----
    always @(negedge clk) begin
        if (rst_n && word_valid && ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                check("word", 32'(word_out), 32'(mon_e.word));
                check("last", 32'(word_last), 32'(mon_e.last));
                check("pad",  32'(pad_bits), 32'(mon_e.pad));
                if (mon_e.lat) check("latency", 32'(cyc), 32'(mon_e.cyc));
                m_occ--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",  32'(word_valid), 32'd0);
        check("rst_word",   32'(word_out),   32'd0);
        check("rst_count",  32'(bit_count),  32'd0);
        check("rst_ovf",    32'(overflow),   32'd0);
        check("rst_done",   32'(done),       32'd0);
        check("rst_last",   32'(word_last),  32'd0);
        rst_n = 1'b1;

        // bits in IDLE are ignored
        @(posedge clk); #1; bit_vld = 1'b1; bit_in = 1'b1;
        idle(2);
        @(negedge clk);
        check("idle_ignored_count", 32'(bit_count), 32'd0);
        check("idle_ignored_valid", 32'(word_valid), 32'd0);

        // 16 bits streaming with ready=1, 1-cycle latency
        ready = 1'b1;
        pulse_start();
        lat_chk = 1'b1;
        send_bits(8'hAC, 8);
        send_bits(8'h71, 8);
        lat_chk = 1'b0;
        idle(3);
        @(negedge clk);
        check("a_bit_count", 32'(bit_count), 32'(m_cnt));
        check("a_sb_empty",  32'(sb.size()), 32'd0);

        // 11 bits then flush: F0, then A0 padded by 5
        pulse_start();
        send_bits(8'hF0, 8);
        send_bits(8'hA0, 3);
        do_flush(1'b0, 1'b0);
        wait_done("b_done");
        check("b_sb_empty", 32'(sb.size()), 32'd0);
        check("b_bit_count", 32'(bit_count), 32'd11);

        // one full word held, flush on word boundary re-tags it
        ready = 1'b0;
        pulse_start();
        send_bits(8'h3C, 8);
        do_flush(1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        check("c_valid", 32'(word_valid), 32'd1);
        check("c_word",  32'(word_out),   32'h3C);
        check("c_last",  32'(word_last),  32'd1);
        check("c_pad",   32'(pad_bits),   32'd0);
        check("c_no_early_done", 32'(done), 32'd0);
        @(posedge clk); #1; ready = 1'b1;
        wait_done("c_done");
        check("c_sb_empty", 32'(sb.size()), 32'd0);
        // bits in DONE are ignored
        @(posedge clk); #1; bit_vld = 1'b1; bit_in = 1'b1;
        idle(3);
        @(negedge clk);
        check("c_done_ignored_count", 32'(bit_count), 32'd8);
        check("c_done_ignored_valid", 32'(word_valid), 32'd0);

        // overflow: 5 words into a 4-deep FIFO with ready=0
        ready = 1'b0;
        pulse_start();
        for (int k = 1; k <= 5; k++) send_bits(8'(8'h11 * k), 8);
        idle(2);
        @(negedge clk);
        check("d_overflow", 32'(overflow),   32'd1);
        check("d_valid",    32'(word_valid), 32'd1);
        check("d_head",     32'(word_out),   32'h11);
        check("d_model_occ", 32'(m_occ),     32'(DEPTH));
        pulse_start();
        @(negedge clk);
        check("d_ovf_sticky", 32'(overflow),   32'd1);
        check("d_start_clr",  32'(word_valid), 32'd0);
        check("d_start_cnt",  32'(bit_count),  32'd0);

        // flush together with the 8th bit: one word, last, no pad
        ready = 1'b1;
        pulse_start();
        send_bits(8'hCD, 7);
        do_flush(1'b1, 1'b1);
        wait_done("e_done");
        check("e_sb_empty",  32'(sb.size()), 32'd0);
        check("e_bit_count", 32'(bit_count), 32'd8);

        // asynchronous reset mid-stream
        pulse_start();
        send_bits(8'hF8, 5);
        @(posedge clk); #1;
        bit_vld = 1'b0;
        rst_n = 1'b0;
        #2;
        check("f_rst_count", 32'(bit_count),  32'd0);
        check("f_rst_valid", 32'(word_valid), 32'd0);
        check("f_rst_ovf",   32'(overflow),   32'd0);
        check("f_rst_word",  32'(word_out),   32'd0);
        sb.delete();
        m_occ = 0; m_shift = '0; m_idx = 0; m_cnt = 0;
        idle(2);
        rst_n = 1'b1;
        pulse_start();
        send_bits(8'h5A, 8);
        idle(3);
        @(negedge clk);
        check("f_sb_empty",  32'(sb.size()), 32'd0);
        check("f_bit_count", 32'(bit_count), 32'd8);
        check("f_ovf",       32'(overflow),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
